// File: rtl/fw_scan_chain_reader_pkg.sv
// ----------------------------------------------------------------------------
// fw_scan_chain_reader_pkg
// Shared definitions for the scan-chain readback block: chain length, number
// of packed readback words and the capture state encoding.
// ----------------------------------------------------------------------------
package fw_scan_chain_reader_pkg;

   // Total number of bits in the ASIC scan chain.
   localparam int scan_reg_bits_total = 768;

   // Number of 32-bit words needed to hold one full scan image.
   localparam int scan_rd_words = scan_reg_bits_total / 32;

   // Capture sequencer states.
   typedef enum logic [1:0] {
      IDLE_SR    = 2'b00,
      CAPTURE_SR = 2'b01,
      DONE_SR    = 2'b10
   } state_t_sm_scan_rd;

endpackage

// File: rtl/fw_scan_chain_reader.sv
// ----------------------------------------------------------------------------
// fw_scan_chain_reader
// Captures a serial scan-chain image (LSB-first) into a bank of packed words
// and offers a one-cycle-latency word read port.
//
// Ports
//   fw_axi_clk  in   single clock, rising edge
//   fw_rst      in   synchronous active-high reset
//   start       in   one-cycle pulse arming a capture (accepted only in IDLE)
//   shift_en    in   strobe qualifying scan_out (used only in CAPTURE)
//   scan_out    in   serial data from the scan chain
//   busy        out  high while capturing
//   done        out  one-cycle pulse after the last bit is stored
//   data_ready  out  high from done until the next accepted start or reset
//   rd_req      in   read strobe
//   rd_index    in   word index
//   rd_data     out  registered read word, holds when rd_valid=0
//   rd_valid    out  one-cycle pulse qualifying rd_data
//   rd_err      out  one-cycle pulse for an out-of-range index
// ----------------------------------------------------------------------------
module fw_scan_chain_reader
   import fw_scan_chain_reader_pkg::*;
#(
   parameter int SCAN_BITS = scan_reg_bits_total,
   parameter int WORD_W    = 32
) (
   input  logic              fw_axi_clk,
   input  logic              fw_rst,
   input  logic              start,
   input  logic              shift_en,
   input  logic              scan_out,
   output logic              busy,
   output logic              done,
   output logic              data_ready,
   input  logic              rd_req,
   input  logic [4:0]        rd_index,
   output logic [WORD_W-1:0] rd_data,
   output logic              rd_valid,
   output logic              rd_err
);

   localparam int NUM_WORDS = SCAN_BITS / WORD_W;

   state_t_sm_scan_rd state_r;
   state_t_sm_scan_rd state_next_s;

   logic [4:0]        bit_cnt_r;
   logic [4:0]        word_cnt_r;
   logic [WORD_W-1:0] pack_r;
   logic [WORD_W-1:0] storage_r [0:NUM_WORDS-1];

   logic              busy_r;
   logic              done_r;
   logic              data_ready_r;
   logic [WORD_W-1:0] rd_data_r;
   logic              rd_valid_r;
   logic              rd_err_r;

   logic              capture_start_s;
   logic              sample_s;
   logic              word_full_s;
   logic              last_bit_s;
   logic [WORD_W-1:0] pack_next_s;

   // New bit enters at the MSB so that after WORD_W shifts the first bit sits in bit 0.
   assign pack_next_s = {scan_out, pack_r[WORD_W-1:1]};

   // Next-state and capture control decode.
   always_comb begin
      state_next_s    = state_r;
      capture_start_s = 1'b0;
      sample_s        = 1'b0;
      word_full_s     = 1'b0;
      last_bit_s      = 1'b0;
      case (state_r)
         IDLE_SR: begin
            if (start) begin
               state_next_s    = CAPTURE_SR;
               capture_start_s = 1'b1;
            end else begin
               state_next_s = IDLE_SR;
            end
         end
         CAPTURE_SR: begin
            if (shift_en) begin
               sample_s = 1'b1;
               if (bit_cnt_r == 5'(WORD_W - 1)) begin
                  word_full_s = 1'b1;
                  if (word_cnt_r == 5'(NUM_WORDS - 1)) begin
                     last_bit_s   = 1'b1;
                     state_next_s = DONE_SR;
                  end else begin
                     state_next_s = CAPTURE_SR;
                  end
               end else begin
                  state_next_s = CAPTURE_SR;
               end
            end else begin
               state_next_s = CAPTURE_SR;
            end
         end
         DONE_SR: begin
            state_next_s = IDLE_SR;
         end
         default: begin
            state_next_s = IDLE_SR;
         end
      endcase
   end

   // State register and registered status flags.
   always_ff @(posedge fw_axi_clk) begin
      if (fw_rst) begin
         state_r      <= IDLE_SR;
         busy_r       <= 1'b0;
         done_r       <= 1'b0;
         data_ready_r <= 1'b0;
      end else begin
         state_r <= state_next_s;
         busy_r  <= (state_next_s == CAPTURE_SR);
         done_r  <= (state_next_s == DONE_SR);
         if (capture_start_s) begin
            data_ready_r <= 1'b0;
         end else if (last_bit_s) begin
            data_ready_r <= 1'b1;
         end
      end
   end

   // Bit/word counters and the packing shift register.
   always_ff @(posedge fw_axi_clk) begin
      if (fw_rst) begin
         bit_cnt_r  <= 5'd0;
         word_cnt_r <= 5'd0;
         pack_r     <= {WORD_W{1'b0}};
      end else if (capture_start_s) begin
         bit_cnt_r  <= 5'd0;
         word_cnt_r <= 5'd0;
         pack_r     <= {WORD_W{1'b0}};
      end else if (sample_s) begin
         pack_r <= pack_next_s;
         if (word_full_s) begin
            bit_cnt_r <= 5'd0;
            // Hold at the last word; the FSM leaves CAPTURE on this cycle.
            if (!last_bit_s) begin
               word_cnt_r <= word_cnt_r + 5'd1;
            end
         end else begin
            bit_cnt_r <= bit_cnt_r + 5'd1;
         end
      end
   end

   // Word storage: cleared on reset, written when a word completes.
   always_ff @(posedge fw_axi_clk) begin
      if (fw_rst) begin
         for (int i = 0; i < NUM_WORDS; i++) begin
            storage_r[i] <= {WORD_W{1'b0}};
         end
      end else if (word_full_s) begin
         storage_r[word_cnt_r] <= pack_next_s;
      end
   end

   // Read port; a same-cycle write is not visible until the following read.
   always_ff @(posedge fw_axi_clk) begin
      if (fw_rst) begin
         rd_data_r  <= {WORD_W{1'b0}};
         rd_valid_r <= 1'b0;
         rd_err_r   <= 1'b0;
      end else if (rd_req) begin
         rd_valid_r <= 1'b1;
         if (rd_index < 5'(NUM_WORDS)) begin
            rd_data_r <= storage_r[rd_index];
            rd_err_r  <= 1'b0;
         end else begin
            rd_data_r <= {WORD_W{1'b0}};
            rd_err_r  <= 1'b1;
         end
      end else begin
         rd_valid_r <= 1'b0;
         rd_err_r   <= 1'b0;
      end
   end

   assign busy       = busy_r;
   assign done       = done_r;
   assign data_ready = data_ready_r;
   assign rd_data    = rd_data_r;
   assign rd_valid   = rd_valid_r;
   assign rd_err     = rd_err_r;

endmodule

// File: tb/tb_fw_scan_chain_reader.sv
// ----------------------------------------------------------------------------
// tb_fw_scan_chain_reader
// Self-checking bench: a word-array model built directly from the serial
// stream, a table of read vectors, and hand sequences for abort, ignored
// start/shift and read-during-write.
// ----------------------------------------------------------------------------
module tb_fw_scan_chain_reader;

   localparam int NBITS  = 768;
   localparam int NWORDS = 24;

   logic        clk = 1'b0;
   logic        fw_rst = 1'b1;
   logic        start = 1'b0;
   logic        shift_en = 1'b0;
   logic        scan_out = 1'b0;
   logic        busy, done, data_ready;
   logic        rd_req = 1'b0;
   logic [4:0]  rd_index = 5'd0;
   logic [31:0] rd_data;
   logic        rd_valid, rd_err;

   int n_cmp = 0;
   int n_fail = 0;

   logic        stream [NBITS];
   logic [31:0] model_mem [NWORDS];

   typedef struct {
      logic [4:0]  idx;
      logic [31:0] exp_data;
      logic        exp_err;
   } rd_vec_t;

   rd_vec_t vecs [6];

   fw_scan_chain_reader dut (
      .fw_axi_clk (clk),
      .fw_rst     (fw_rst),
      .start      (start),
      .shift_en   (shift_en),
      .scan_out   (scan_out),
      .busy       (busy),
      .done       (done),
      .data_ready (data_ready),
      .rd_req     (rd_req),
      .rd_index   (rd_index),
      .rd_data    (rd_data),
      .rd_valid   (rd_valid),
      .rd_err     (rd_err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Model: word k holds stream bits 32k..32k+31, first bit in bit 0.
   task automatic model_from_stream();
      for (int k = 0; k < NWORDS; k++)
         for (int b = 0; b < 32; b++)
            model_mem[k][b] = stream[32 * k + b];
   endtask

   task automatic model_clear();
      for (int k = 0; k < NWORDS; k++) model_mem[k] = 32'h0;
   endtask

   task automatic read_word(input logic [4:0] idx, input logic [31:0] exp_d,
                            input logic exp_e, input bit check_hold);
      rd_req = 1'b1;
      rd_index = idx;
      tick();
      rd_req = 1'b0;
      chk($sformatf("rd_valid[%0d]", idx), {31'd0, rd_valid}, 32'd1);
      chk($sformatf("rd_err[%0d]", idx), {31'd0, rd_err}, {31'd0, exp_e});
      chk($sformatf("rd_data[%0d]", idx), rd_data, exp_d);
      if (check_hold) begin
         tick();
         chk("rd_valid_drop", {31'd0, rd_valid}, 32'd0);
         chk("rd_err_drop", {31'd0, rd_err}, 32'd0);
         chk("rd_data_hold", rd_data, exp_d);
      end
   endtask

   task automatic read_all_model(input string tag);
      for (int k = 0; k < NWORDS; k++) read_word(5'(k), model_mem[k], 1'b0, 1'b0);
      chk({tag, "_ready"}, {31'd0, data_ready}, {31'd0, (tag == "cap") ? 1'b1 : 1'b0});
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
      chk({tag, "_done"}, {31'd0, done}, 32'd0);
      chk({tag, "_data_ready"}, {31'd0, data_ready}, 32'd0);
      chk({tag, "_rd_valid"}, {31'd0, rd_valid}, 32'd0);
      chk({tag, "_rd_err"}, {31'd0, rd_err}, 32'd0);
      chk({tag, "_rd_data"}, rd_data, 32'd0);
   endtask

   // One capture of 'stream'. abort_at>=0 resets before that bit is strobed;
   // restart_at>=0 pulses a stray start before that bit; rd_word>=0 reads
   // that word in the cycle its last bit is written.
   task automatic run_capture(input int gap_max, input bit start_with_shift,
                              input int restart_at, input int abort_at, input int rd_word);
      logic [31:0] old_mem [NWORDS];
      for (int k = 0; k < NWORDS; k++) old_mem[k] = model_mem[k];
      start = 1'b1;
      if (start_with_shift) begin
         shift_en = 1'b1;
         scan_out = ~stream[0];
      end
      tick();
      start = 1'b0;
      shift_en = 1'b0;
      chk("cap_busy_start", {31'd0, busy}, 32'd1);
      chk("cap_ready_clr", {31'd0, data_ready}, 32'd0);
      for (int i = 0; i < NBITS; i++) begin
         if (i == abort_at) begin
            fw_rst = 1'b1;
            tick();
            fw_rst = 1'b0;
            model_clear();
            return;
         end
         if (i == restart_at) begin
            start = 1'b1;
            tick();
            start = 1'b0;
            chk("stray_start_busy", {31'd0, busy}, 32'd1);
         end
         repeat ($urandom_range(gap_max, 0)) begin
            tick();
            if (busy !== 1'b1 || done !== 1'b0) chk("gap_busy", {30'd0, busy, done}, 32'd2);
         end
         shift_en = 1'b1;
         scan_out = stream[i];
         if (rd_word >= 0 && i == rd_word * 32 + 31) begin
            rd_req = 1'b1;
            rd_index = 5'(rd_word);
         end
         tick();
         shift_en = 1'b0;
         if (rd_req) begin
            rd_req = 1'b0;
            chk("rdw_valid", {31'd0, rd_valid}, 32'd1);
            chk("rdw_old", rd_data, old_mem[rd_word]);
         end
         if (i < NBITS - 1) begin
            if (busy !== 1'b1 || done !== 1'b0) chk("cap_busy", {30'd0, busy, done}, 32'd2);
         end else begin
            chk("end_done", {31'd0, done}, 32'd1);
            chk("end_busy", {31'd0, busy}, 32'd0);
            chk("end_ready", {31'd0, data_ready}, 32'd1);
         end
      end
      model_from_stream();
      tick();
      chk("done_once", {31'd0, done}, 32'd0);
      chk("ready_hold", {31'd0, data_ready}, 32'd1);
      if (rd_word >= 0) read_word(5'(rd_word), model_mem[rd_word], 1'b0, 1'b0);
   endtask

   initial begin
      #4000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      // Reset state
      tick();
      tick();
      fw_rst = 1'b0;
      check_reset_outputs("reset");
      model_clear();

      // shift_en while IDLE must not touch storage
      for (int i = 0; i < 5; i++) begin
         shift_en = 1'b1;
         scan_out = 1'b1;
         tick();
      end
      shift_en = 1'b0;
      chk("idle_shift_busy", {31'd0, busy}, 32'd0);
      read_word(5'd0, 32'h0, 1'b0, 1'b0);

      // Alternating pattern, start with shift in same cycle, stray start at bit 100
      for (int i = 0; i < NBITS; i++) stream[i] = i[0];
      run_capture(0, 1'b1, 100, -1, -1);
      vecs[0] = '{5'd0,  32'hAAAA_AAAA, 1'b0};
      vecs[1] = '{5'd5,  32'hAAAA_AAAA, 1'b0};
      vecs[2] = '{5'd23, 32'hAAAA_AAAA, 1'b0};
      vecs[3] = '{5'd24, 32'h0,         1'b1};
      vecs[4] = '{5'd31, 32'h0,         1'b1};
      vecs[5] = '{5'd12, 32'hAAAA_AAAA, 1'b0};
      for (int v = 0; v < 6; v++) read_word(vecs[v].idx, vecs[v].exp_data, vecs[v].exp_err, 1'b1);
      read_all_model("cap");

      // Word-index stream with random gaps; read word 5 as it is written
      for (int k = 0; k < NWORDS; k++)
         for (int b = 0; b < 32; b++) begin
            logic [31:0] w;
            w = 32'(k);
            stream[32 * k + b] = w[b];
         end
      run_capture(5, 1'b0, -1, -1, 5);
      for (int k = 0; k < NWORDS; k++) read_word(5'(k), 32'(k), 1'b0, 1'b0);

      // Abort after 400 bits, then all-ones recapture
      for (int i = 0; i < NBITS; i++) stream[i] = $urandom_range(1, 0);
      run_capture(2, 1'b0, -1, 400, -1);
      check_reset_outputs("abort");
      read_all_model("abort");
      for (int i = 0; i < NBITS; i++) stream[i] = 1'b1;
      run_capture(1, 1'b0, -1, -1, -1);
      for (int k = 0; k < NWORDS; k++) read_word(5'(k), 32'hFFFF_FFFF, 1'b0, 1'b0);

      // Random data, random gaps
      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < NBITS; i++) stream[i] = $urandom_range(1, 0);
         run_capture(3, 1'b0, -1, -1, $urandom_range(23, 0));
         read_all_model("cap");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/fw_scan_chain_reader.md
FW_SCAN_CHAIN_READER -- requirements
Module: fw_scan_chain_reader

Interface
REQ-001 SHALL have parameter SCAN_BITS, default 768 (scan_reg_bits_total), meaning scan-chain length in bits.
REQ-002 SHALL have parameter WORD_W, default 32, meaning packed readback word width; SCAN_BITS/WORD_W (24) words are stored.
REQ-003 SHALL have port fw_axi_clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port fw_rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  input  1  one-cycle pulse that arms a capture.
REQ-006 SHALL have port shift_en  input  1  one-cycle strobe marking a valid scan_out sample.
REQ-007 SHALL have port scan_out  input  1  serial data from the ASIC scan chain, sampled only when shift_en=1.
REQ-008 SHALL have port busy  output  1  high while capturing.
REQ-009 SHALL have port done  output  1  one-cycle pulse when the last bit is stored.
REQ-010 SHALL have port data_ready  output  1  high from done until the next start or reset.
REQ-011 SHALL have port rd_req  input  1  read strobe.
REQ-012 SHALL have port rd_index  input  5  word index, 0..23.
REQ-013 SHALL have port rd_data  output  32  registered read word.
REQ-014 SHALL have port rd_valid  output  1  one-cycle pulse qualifying rd_data.
REQ-015 SHALL have port rd_err  output  1  one-cycle pulse for an out-of-range index.

Function
REQ-016 SHALL implement FSM states IDLE, CAPTURE, DONE.
REQ-017 IDLE->CAPTURE on start=1; clears bit counter, word counter and data_ready.
REQ-018 In CAPTURE each shift_en=1 cycle SHALL shift scan_out into a 32-bit packing register, LSB-first; the first received bit lands in word bit 0.
REQ-019 On the 32nd bit of a word SHALL write the completed word to storage[word_cnt] in that cycle, then increment word_cnt and clear the bit count.
REQ-020 After bit SCAN_BITS (word 23 written) SHALL go CAPTURE->DONE; DONE lasts exactly one cycle, asserts done, sets data_ready, then returns to IDLE.
REQ-021 busy SHALL be 1 exactly while the state is CAPTURE.
REQ-022 start during CAPTURE or DONE SHALL be ignored; shift_en outside CAPTURE SHALL be ignored with storage unchanged.
REQ-023 start and shift_en in the same IDLE cycle: the start is accepted and that bit is not sampled.
REQ-024 A gap of any length between shift_en strobes SHALL not alter the result.
REQ-025 rd_req=1 with rd_index<24 SHALL return storage[rd_index] on rd_data with rd_valid=1 on the next cycle (latency 1), in any state.
REQ-026 rd_req=1 with rd_index>=24 SHALL return rd_data=0 with rd_valid=1 and rd_err=1 on the next cycle.
REQ-027 A read of a word in the same cycle that word is written SHALL return the old value.
REQ-028 rd_data SHALL hold its last value when rd_valid=0.
REQ-029 Bit counter SHALL be 5 bits and word counter 5 bits; neither wraps, because the FSM exits CAPTURE at the limit.

Reset
REQ-030 fw_rst=1 SHALL, on the next edge, force IDLE and set busy=0, done=0, data_ready=0, rd_valid=0, rd_err=0 and rd_data=0.
REQ-031 fw_rst=1 SHALL also clear the counters, the packing register and all 24 storage words to 0.
REQ-032 Reset in mid-capture SHALL abort the capture and leave no partial data.

Structure
REQ-033 The package SHALL hold typedef enum logic [1:0] state_t_sm_scan_rd {IDLE_SR=2'b00, CAPTURE_SR=2'b01, DONE_SR=2'b10}.
REQ-034 The package SHALL hold parameter scan_rd_words = scan_reg_bits_total/32.
REQ-035 Storage SHALL be an in-module register array, with no sub-module.

Verification
REQ-036 Reset, start, 768 strobes of pattern bit[i]=i[0] -> every word reads 32'hAAAA_AAAA, done pulses once, busy is high for the whole capture.
REQ-037 Serial stream of words 32'h0000_0000 to 32'h0000_0017 (LSB-first), with random 0-5 cycle strobe gaps -> rd_index=k returns k one cycle later.
REQ-038 rd_index=24 and rd_index=31 -> rd_data=0, rd_valid=1, rd_err=1; storage unchanged.
REQ-039 fw_rst asserted after 400 bits, then a full all-ones capture -> all words read 32'hFFFF_FFFF; before the recapture, all words read 0 and data_ready=0.
REQ-040 Second start at bit 100 and shift_en while IDLE -> both ignored; bit count and data unaffected.
REQ-041 Read word 5 in the cycle it is written -> old value returned; the next read returns the new value.
